// File: rtl/panel_switches_pkg.sv
// Shared front-panel definitions: scan FSM encoding and default scan timing,
// common to the switch reader and the display driver.
package panel_switches_pkg;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2,
    ST_WAIT   = 2'd3
  } panel_state_e;

  localparam int unsigned PANEL_NUM_BITS  = 32;
  localparam int unsigned PANEL_CLK_DIV   = 16;
  localparam int unsigned PANEL_SCAN_WAIT = 65536;
  localparam int unsigned PANEL_DEBOUNCE  = 4;

endpackage

// File: rtl/panel_switch_debounce.sv
// Scan-to-scan debouncer: commits a raw switch word once it has been seen on
// DEBOUNCE consecutive scans, and flags commits that change the presented value.
module panel_switch_debounce #(
  parameter int unsigned NUM_BITS = 32,
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_BITS-1:0] raw,
  input  logic                commit,
  output logic [NUM_BITS-1:0] switches,
  output logic                changed,
  output logic                switches_valid
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE + 1);
  localparam int unsigned CMP_W = CNT_W + 1;

  logic [NUM_BITS-1:0] prev_raw;
  logic [CNT_W-1:0]    stable_cnt;
  logic [CNT_W-1:0]    cnt_upd;
  logic                take;

  // Stability count after this scan, saturating at DEBOUNCE
  always_comb begin
    cnt_upd = '0;
    take    = 1'b0;
    if (raw == prev_raw) begin
      cnt_upd = (stable_cnt == CNT_W'(DEBOUNCE)) ? stable_cnt : stable_cnt + CNT_W'(1);
    end
    take = (CMP_W'(cnt_upd) + CMP_W'(1)) >= CMP_W'(DEBOUNCE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_raw       <= '0;
      stable_cnt     <= '0;
      switches       <= '0;
      changed        <= 1'b0;
      switches_valid <= 1'b0;
    end else begin
      changed <= 1'b0;
      if (commit) begin
        prev_raw   <= raw;
        stable_cnt <= cnt_upd;
        if (take) begin
          switches       <= raw;
          switches_valid <= 1'b1;
          changed        <= (raw != switches) || !switches_valid;
        end
      end
    end
  end

endmodule

// File: rtl/panel_switches.sv
// Front-panel switch reader: scans a 74HC165-style PISO chain and presents a
// debounced switch vector with a change strobe.
module panel_switches
  import panel_switches_pkg::*;
#(
  parameter int unsigned NUM_BITS  = PANEL_NUM_BITS,
  parameter int unsigned CLK_DIV   = PANEL_CLK_DIV,
  parameter int unsigned SCAN_WAIT = PANEL_SCAN_WAIT,
  parameter int unsigned DEBOUNCE  = PANEL_DEBOUNCE
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sdata,
  output logic                sclk,
  output logic                sload_n,
  output logic [NUM_BITS-1:0] switches,
  output logic                changed,
  output logic                switchesValid
);

  localparam int unsigned LOAD_CYC = 2 * CLK_DIV;
  localparam int unsigned CNT_MAX  = (SCAN_WAIT > LOAD_CYC) ? SCAN_WAIT : LOAD_CYC;
  localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);
  localparam int unsigned BIT_W    = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;

  panel_state_e        state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [BIT_W-1:0]    bit_cnt, bit_nxt;
  logic                phase, phase_nxt;
  logic                sclk_nxt, sload_n_nxt;
  logic                sample;
  logic [1:0]          sync;
  logic [NUM_BITS-1:0] raw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_LOAD;
      cnt     <= '0;
      bit_cnt <= '0;
      phase   <= 1'b0;
      sclk    <= 1'b0;
      sload_n <= 1'b1;
      sync    <= '0;
      raw     <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_cnt <= bit_nxt;
      phase   <= phase_nxt;
      sclk    <= sclk_nxt;
      sload_n <= sload_n_nxt;
      sync    <= {sync[0], sdata};
      if (sample) raw <= NUM_BITS'({raw, sync[1]});
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    bit_nxt     = bit_cnt;
    phase_nxt   = phase;
    sample      = 1'b0;
    sclk_nxt    = 1'b0;
    sload_n_nxt = 1'b1;
    case (state)
      // The cycle straight out of reset only asserts the load; counting starts once it is low
      ST_LOAD: begin
        if (!sload_n) begin
          if (cnt == CNT_W'(LOAD_CYC - 1)) begin
            state_nxt = ST_SHIFT;
            cnt_nxt   = '0;
            bit_nxt   = '0;
            phase_nxt = 1'b0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
      ST_SHIFT: begin
        if (cnt == CNT_W'(CLK_DIV - 1)) begin
          cnt_nxt = '0;
          if (!phase) begin
            sample    = 1'b1;
            phase_nxt = 1'b1;
          end else begin
            phase_nxt = 1'b0;
            if (bit_cnt == BIT_W'(NUM_BITS - 1)) state_nxt = ST_COMMIT;
            else bit_nxt = bit_cnt + BIT_W'(1);
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ST_COMMIT: begin
        state_nxt = ST_WAIT;
        cnt_nxt   = '0;
      end
      ST_WAIT: begin
        if (cnt == CNT_W'(SCAN_WAIT - 1)) begin
          state_nxt = ST_LOAD;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: state_nxt = ST_LOAD;
    endcase
    sclk_nxt    = (state_nxt == ST_SHIFT) && phase_nxt;
    sload_n_nxt = (state_nxt != ST_LOAD);
  end

  panel_switch_debounce #(
    .NUM_BITS (NUM_BITS),
    .DEBOUNCE (DEBOUNCE)
  ) u_debounce (
    .clk            (clk),
    .rst_n          (rst_n),
    .raw            (raw),
    .commit         (state == ST_COMMIT),
    .switches       (switches),
    .changed        (changed),
    .switches_valid (switchesValid)
  );

endmodule

// File: tb/tb_panel_switches.sv
// Bench for panel_switches: behavioural PISO chain models drive two instances
// (32-bit debounced, 8-bit undebounced) checked against a scan-history model.
module tb_panel_switches;

  localparam int NB_A = 32, CD_A = 4, SW_A = 20, DB_A = 4;
  localparam int NB_B = 8,  CD_B = 4, SW_B = 10, DB_B = 1;
  localparam int SCAN_A = (2 + 2 * NB_A) * CD_A + 1 + SW_A;
  localparam int SCAN_B = (2 + 2 * NB_B) * CD_B + 1 + SW_B;

  logic clk;
  logic rst_a, rst_b;
  logic sdata_a, sclk_a, sload_n_a, changed_a, valid_a;
  logic sdata_b, sclk_b, sload_n_b, changed_b, valid_b;
  logic [NB_A-1:0] switches_a;
  logic [NB_B-1:0] switches_b;

  int errors = 0;
  int checks = 0;

  panel_switches #(.NUM_BITS(NB_A), .CLK_DIV(CD_A), .SCAN_WAIT(SW_A), .DEBOUNCE(DB_A)) dut_a (
    .clk(clk), .rst_n(rst_a), .sdata(sdata_a), .sclk(sclk_a), .sload_n(sload_n_a),
    .switches(switches_a), .changed(changed_a), .switchesValid(valid_a)
  );

  panel_switches #(.NUM_BITS(NB_B), .CLK_DIV(CD_B), .SCAN_WAIT(SW_B), .DEBOUNCE(DB_B)) dut_b (
    .clk(clk), .rst_n(rst_b), .sdata(sdata_b), .sclk(sclk_b), .sload_n(sload_n_b),
    .switches(switches_b), .changed(changed_b), .switchesValid(valid_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 74HC165 chain: asynchronous parallel load, shift on sclk rise, QH = bit NB-1
  logic [NB_A-1:0] chain_a = '0, sh_a = '0;
  logic [NB_B-1:0] chain_b = '0, sh_b = '0;
  always @(posedge sclk_a or negedge sload_n_a)
    if (!sload_n_a) sh_a <= chain_a; else sh_a <= sh_a << 1;
  always @(posedge sclk_b or negedge sload_n_b)
    if (!sload_n_b) sh_b <= chain_b; else sh_b <= sh_b << 1;
  assign sdata_a = sh_a[NB_A-1];
  assign sdata_b = sh_b[NB_B-1];

  // Output monitor: counts cycles with changed high and first changed/valid cycles
  int cyc = 0;
  int chg_cnt_a = 0, chg_cnt_b = 0;
  int first_chg_a = -1, first_val_a = -1;
  always @(negedge clk) begin
    cyc++;
    if (changed_a) begin
      chg_cnt_a++;
      if (first_chg_a < 0) first_chg_a = cyc;
    end
    if (valid_a && first_val_a < 0) first_val_a = cyc;
    if (changed_b) chg_cnt_b++;
  end

  // Reference model: a new word commits once it heads a run of DEBOUNCE equal scans;
  // the reset value 0 of the previous-scan register counts as one prior scan of 0
  logic [31:0] hist_a[$], hist_b[$];
  logic [31:0] exp_sw_a, exp_sw_b;
  logic        exp_val_a, exp_val_b;

  function automatic int trailing_run(input logic [31:0] q[$]);
    int n;
    n = 1;
    for (int i = q.size() - 2; i >= 0; i--) begin
      if (q[i] != q[q.size()-1]) break;
      n++;
    end
    return n;
  endfunction

  task automatic model_reset_a();
    hist_a.delete(); hist_a.push_back('0); exp_sw_a = '0; exp_val_a = 1'b0;
  endtask

  task automatic model_reset_b();
    hist_b.delete(); hist_b.push_back('0); exp_sw_b = '0; exp_val_b = 1'b0;
  endtask

  task automatic model_a(input logic [31:0] v, output int pulse);
    hist_a.push_back(v);
    pulse = 0;
    if (trailing_run(hist_a) >= DB_A) begin
      pulse = ((v != exp_sw_a) || !exp_val_a) ? 1 : 0;
      exp_sw_a = v; exp_val_a = 1'b1;
    end
  endtask

  task automatic model_b(input logic [31:0] v, output int pulse);
    hist_b.push_back(v);
    pulse = 0;
    if (trailing_run(hist_b) >= DB_B) begin
      pulse = ((v != exp_sw_b) || !exp_val_b) ? 1 : 0;
      exp_sw_b = v; exp_val_b = 1'b1;
    end
  endtask

  // One full scan: present v, wait for the load and shift, stop a few cycles into WAIT
  task automatic scan_a(input logic [NB_A-1:0] v, output int delta);
    int n, c0;
    chain_a = v; c0 = chg_cnt_a; n = 0;
    while (sload_n_a !== 1'b0 && n < 2 * SCAN_A) begin @(negedge clk); n++; end
    while (sload_n_a !== 1'b1 && n < 2 * SCAN_A) begin @(negedge clk); n++; end
    checks++;
    if (n >= 2 * SCAN_A) begin errors++; $display("FAIL scan_a_timeout: waited %0d cycles, limit %0d", n, 2 * SCAN_A); end
    repeat (2 * NB_A * CD_A + 5) @(negedge clk);
    delta = chg_cnt_a - c0;
  endtask

  task automatic scan_b(input logic [NB_B-1:0] v, output int delta);
    int n, c0;
    chain_b = v; c0 = chg_cnt_b; n = 0;
    while (sload_n_b !== 1'b0 && n < 2 * SCAN_B) begin @(negedge clk); n++; end
    while (sload_n_b !== 1'b1 && n < 2 * SCAN_B) begin @(negedge clk); n++; end
    checks++;
    if (n >= 2 * SCAN_B) begin errors++; $display("FAIL scan_b_timeout: waited %0d cycles, limit %0d", n, 2 * SCAN_B); end
    repeat (2 * NB_B * CD_B + 5) @(negedge clk);
    delta = chg_cnt_b - c0;
  endtask

  task automatic test_reset();
    rst_a = 1'b0; rst_b = 1'b0;
    repeat (3) @(negedge clk);
    checks += 5;
    if (sclk_a !== 1'b0)      begin errors++; $display("FAIL reset_sclk: got %b want 0", sclk_a); end
    if (sload_n_a !== 1'b1)   begin errors++; $display("FAIL reset_sload_n: got %b want 1", sload_n_a); end
    if (switches_a !== '0)    begin errors++; $display("FAIL reset_switches: got %h want 0", switches_a); end
    if (changed_a !== 1'b0)   begin errors++; $display("FAIL reset_changed: got %b want 0", changed_a); end
    if (valid_a !== 1'b0)     begin errors++; $display("FAIL reset_valid: got %b want 0", valid_a); end
  endtask

  task automatic test_waveform();
    int n, bad, first_bad, rises, low;
    logic prev_sclk, exp_sl, exp_sc;
    rst_b = 1'b0;
    repeat (3) @(negedge clk);
    rst_b = 1'b1;
    n = 0;
    while (sload_n_b !== 1'b0 && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (n >= 50) begin errors++; $display("FAIL wave_first_load: waited %0d cycles, limit 50", n); end
    bad = 0; first_bad = -1; rises = 0; low = 0; prev_sclk = 1'b0;
    for (int t = 0; t < SCAN_B + 8; t++) begin
      if (t < 2 * CD_B || t >= SCAN_B) begin
        exp_sl = 1'b0; exp_sc = 1'b0;
      end else if (t < 2 * CD_B + 2 * NB_B * CD_B) begin
        exp_sl = 1'b1; exp_sc = (((t - 2 * CD_B) % (2 * CD_B)) >= CD_B);
      end else begin
        exp_sl = 1'b1; exp_sc = 1'b0;
      end
      if (sload_n_b !== exp_sl || sclk_b !== exp_sc) begin
        bad++;
        if (first_bad < 0) first_bad = t;
      end
      if (t < SCAN_B) begin
        if (sclk_b && !prev_sclk) rises++;
        if (!sload_n_b) low++;
      end
      prev_sclk = sclk_b;
      @(negedge clk);
    end
    checks += 3;
    if (bad != 0)      begin errors++; $display("FAIL wave_pattern: %0d bad cycles, first at cycle %0d, want 0", bad, first_bad); end
    if (rises != NB_B) begin errors++; $display("FAIL wave_sclk_edges: got %0d want %0d", rises, NB_B); end
    if (low != 2 * CD_B) begin errors++; $display("FAIL wave_load_len: got %0d want %0d", low, 2 * CD_B); end
  endtask

  task automatic test_static();
    int d, ep, pulses, commit_scan;
    rst_a = 1'b0; chain_a = 32'hA5C3_0F12; model_reset_a();
    first_chg_a = -1; first_val_a = -1;
    repeat (2) @(negedge clk);
    rst_a = 1'b1;
    pulses = 0; commit_scan = -1;
    for (int i = 1; i <= 6; i++) begin
      scan_a(32'hA5C3_0F12, d); model_a(32'hA5C3_0F12, ep);
      pulses += d;
      if (switches_a === 32'hA5C3_0F12 && commit_scan < 0) commit_scan = i;
      checks += 3;
      if (switches_a !== exp_sw_a) begin errors++; $display("FAIL static_sw scan %0d: got %h want %h", i, switches_a, exp_sw_a); end
      if (valid_a !== exp_val_a)   begin errors++; $display("FAIL static_valid scan %0d: got %b want %b", i, valid_a, exp_val_a); end
      if (d != ep)                 begin errors++; $display("FAIL static_changed scan %0d: got %0d want %0d", i, d, ep); end
    end
    checks += 3;
    if (commit_scan != DB_A) begin errors++; $display("FAIL static_commit_scan: got %0d want %0d", commit_scan, DB_A); end
    if (pulses != 1)         begin errors++; $display("FAIL static_pulses: got %0d want 1", pulses); end
    if (first_chg_a != first_val_a || first_chg_a < 0) begin
      errors++; $display("FAIL static_valid_with_changed: changed cycle %0d valid cycle %0d", first_chg_a, first_val_a);
    end
  endtask

  task automatic test_bit_order();
    int d, ep;
    for (int i = 1; i <= 5; i++) begin
      scan_a(32'h8000_0000, d); model_a(32'h8000_0000, ep);
      checks += 2;
      if (switches_a !== exp_sw_a) begin errors++; $display("FAIL order_sw scan %0d: got %h want %h", i, switches_a, exp_sw_a); end
      if (d != ep)                 begin errors++; $display("FAIL order_changed scan %0d: got %0d want %0d", i, d, ep); end
    end
    checks++;
    if (switches_a !== 32'h8000_0000) begin errors++; $display("FAIL order_msb_first: got %h want 80000000", switches_a); end
  endtask

  task automatic test_bounce();
    logic [31:0] seq [8] = '{32'h1, 32'h0, 32'h1, 32'h0, 32'h1, 32'h1, 32'h1, 32'h1};
    int d, ep, pulses;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      scan_a(seq[i], d); model_a(seq[i], ep);
      pulses += d;
      checks += 2;
      if (switches_a !== exp_sw_a) begin errors++; $display("FAIL bounce_sw scan %0d: got %h want %h", i, switches_a, exp_sw_a); end
      if (d != ep)                 begin errors++; $display("FAIL bounce_changed scan %0d: got %0d want %0d", i, d, ep); end
    end
    checks += 2;
    if (switches_a !== 32'h1) begin errors++; $display("FAIL bounce_final: got %h want 00000001", switches_a); end
    if (pulses != 1)          begin errors++; $display("FAIL bounce_pulses: got %0d want 1", pulses); end
  endtask

  task automatic test_random();
    logic [31:0] p0, p1, v;
    int d, ep;
    p0 = $urandom; p1 = $urandom;
    if (p1 == p0) p1 = ~p0;
    v = p0;
    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(0, 2) == 0) v = (v == p0) ? p1 : p0;
      scan_a(v, d); model_a(v, ep);
      checks += 3;
      if (switches_a !== exp_sw_a) begin errors++; $display("FAIL random_sw scan %0d: got %h want %h", i, switches_a, exp_sw_a); end
      if (valid_a !== exp_val_a)   begin errors++; $display("FAIL random_valid scan %0d: got %b want %b", i, valid_a, exp_val_a); end
      if (d != ep)                 begin errors++; $display("FAIL random_changed scan %0d: got %0d want %0d", i, d, ep); end
    end
  endtask

  task automatic test_reset_mid_shift();
    int n, rises, c0, d, ep, pulses;
    logic prev_sclk;
    logic [31:0] v;
    chain_a = 32'h1357_9BDF; n = 0;
    while (sload_n_a !== 1'b0 && n < 2 * SCAN_A) begin @(negedge clk); n++; end
    rises = 0; prev_sclk = sclk_a;
    while (rises < 10 && n < 3 * SCAN_A) begin
      @(negedge clk); n++;
      if (sclk_a && !prev_sclk) rises++;
      prev_sclk = sclk_a;
    end
    checks++;
    if (rises != 10) begin errors++; $display("FAIL midrst_edges: got %0d sclk edges want 10", rises); end
    rst_a = 1'b0;
    #1;
    checks += 5;
    if (sclk_a !== 1'b0)    begin errors++; $display("FAIL midrst_sclk: got %b want 0", sclk_a); end
    if (sload_n_a !== 1'b1) begin errors++; $display("FAIL midrst_sload_n: got %b want 1", sload_n_a); end
    if (switches_a !== '0)  begin errors++; $display("FAIL midrst_switches: got %h want 0", switches_a); end
    if (changed_a !== 1'b0) begin errors++; $display("FAIL midrst_changed: got %b want 0", changed_a); end
    if (valid_a !== 1'b0)   begin errors++; $display("FAIL midrst_valid: got %b want 0", valid_a); end
    c0 = chg_cnt_a;
    repeat (20) @(negedge clk);
    checks++;
    if (chg_cnt_a != c0) begin errors++; $display("FAIL midrst_spurious: got %0d changed cycles want 0", chg_cnt_a - c0); end
    v = 32'h2468_ACE1;
    chain_a = v; model_reset_a();
    rst_a = 1'b1;
    pulses = 0;
    for (int i = 1; i <= DB_A; i++) begin
      scan_a(v, d); model_a(v, ep);
      pulses += d;
      checks += 3;
      if (switches_a !== exp_sw_a) begin errors++; $display("FAIL midrst_sw scan %0d: got %h want %h", i, switches_a, exp_sw_a); end
      if (valid_a !== exp_val_a)   begin errors++; $display("FAIL midrst_valid scan %0d: got %b want %b", i, valid_a, exp_val_a); end
      if (d != ep)                 begin errors++; $display("FAIL midrst_changed scan %0d: got %0d want %0d", i, d, ep); end
    end
    checks++;
    if (pulses != 1) begin errors++; $display("FAIL midrst_pulses: got %0d want 1", pulses); end
  endtask

  task automatic test_debounce1();
    logic [NB_B-1:0] v, prev;
    int d, ep;
    rst_b = 1'b0; chain_b = '0; model_reset_b();
    repeat (2) @(negedge clk);
    rst_b = 1'b1;
    prev = '0;
    for (int i = 0; i < 12; i++) begin
      if (i == 4 || i == 8 || i == 9) v = prev;
      else v = NB_B'($urandom_range(0, 255));
      scan_b(v, d); model_b(32'(v), ep);
      prev = v;
      checks += 3;
      if (32'(switches_b) !== exp_sw_b) begin errors++; $display("FAIL deb1_sw scan %0d: got %h want %h", i, switches_b, exp_sw_b); end
      if (valid_b !== exp_val_b)        begin errors++; $display("FAIL deb1_valid scan %0d: got %b want %b", i, valid_b, exp_val_b); end
      if (d != ep)                      begin errors++; $display("FAIL deb1_changed scan %0d: got %0d want %0d", i, d, ep); end
    end
  endtask

  initial begin
    test_reset();
    test_waveform();
    test_static();
    test_bit_order();
    test_bounce();
    test_random();
    test_reset_mid_shift();
    test_debounce1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/panel_switches.md
# panel_switches

Front-panel switch reader: the input-side counterpart to the panel display driver. It clocks a chain of parallel-in/serial-out shift registers (74HC165-style) that hold the panel's toggle and pushbutton states, and assembles the serial stream into a word. It debounces across consecutive scans and presents a stable switch vector, with a change strobe, to the front-panel controller logic.

## Interface
Parameters:
- NUM_BITS, 32, number of switch bits in the shift-register chain
- CLK_DIV, 16, clk cycles per sclk half-period; must be ≥ 4
- SCAN_WAIT, 65536, idle clk cycles between the end of one scan and the next load
- DEBOUNCE, 4, consecutive identical raw scans required before a new value is committed; must be ≥ 1

Ports (reset rst_n, asynchronous, active-low; clock clk):
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- sdata  in  1  serial data from the last register in the chain (QH), asynchronous to clk
- sclk  out  1  shift clock to the chain; rising edge shifts
- sload_n  out  1  active-low parallel load to the chain
- switches  out  NUM_BITS  debounced switch state; bit NUM_BITS-1 is the first bit shifted out
- changed  out  1  one-cycle pulse when switches takes a new, different value
- switchesValid  out  1  high once the first debounced value is committed; stays high until reset

## Operation
- sdata passes through a 2-flop synchronizer before any use.
- FSM states:
  - LOAD: sload_n=0 and sclk=0 for 2*CLK_DIV cycles, then go to SHIFT.
  - SHIFT: sload_n=1. Runs NUM_BITS sclk periods, each CLK_DIV cycles low then CLK_DIV cycles high. On the last clk of each low half, sample the synchronized sdata into the raw shift register, MSB first. After the last high half, go to COMMIT.
  - COMMIT: 1 cycle. Run the debounce update, then go to WAIT.
  - WAIT: sclk=0, sload_n=1 for SCAN_WAIT cycles, then go to LOAD.
- Debounce, evaluated in COMMIT:
  - If raw equals the previous raw scan, stable_cnt saturates upward; otherwise stable_cnt=0 and prev_raw=raw.
  - When stable_cnt+1 ≥ DEBOUNCE, commit. switches<=raw. changed=1 if raw≠switches or switchesValid was 0. switchesValid<=1.
  - With DEBOUNCE=1, every scan commits.
- The first post-reset commit always pulses changed, even when the value equals 0.

## Timing
- Reset values: sclk=0, sload_n=1, switches=0, changed=0, switchesValid=0, stable_cnt=0, prev_raw=0, FSM=LOAD. The first clk after reset release enters LOAD.
- Scan length: (2+2*NUM_BITS)*CLK_DIV + 1 + SCAN_WAIT cycles, from the first LOAD cycle to the next first LOAD cycle.
- sdata sample point: synchronizer delay is 2 clk cycles. Because CLK_DIV ≥ 4, data launched by the previous sclk rise (or by the load) has been stable at least 2 cycles before sampling.
- changed asserts in the cycle after COMMIT, together with the new switches value, for exactly one cycle.
- switches changes only on commit and is otherwise held stable.
- Reset mid-scan: all outputs return to reset values immediately. The partial raw word is discarded and no commit occurs.
- The toggling pattern of sdata does not affect FSM timing. No stall or handshake exists; consumers sample switches on changed, or at any time once switchesValid=1.
- sclk and sload_n are registered outputs, with no combinational path from sdata.

## Structure
- A shared panel package holds the FSM state encoding (LOAD, SHIFT, COMMIT, WAIT).
- A shared panel package holds default CLK_DIV and SCAN_WAIT constants, shared with the display driver so both panels scan at matching rates.
- One sub-module is natural: panel_switch_debounce, holding prev_raw, stable_cnt, switches, changed and switchesValid. Its inputs are raw[NUM_BITS-1:0] and a commit strobe.
- The top holds the synchronizer, divider counter, bit counter, FSM and raw shift register.

## Test plan
- Reset then static chain value 32'hA5C3_0F12, DEBOUNCE=4:
  - switches becomes A5C30F12 at the end of scan 4.
  - changed pulses once; switchesValid rises in the same cycle.
  - No further changed on later scans.
- Waveform check, NUM_BITS=8, CLK_DIV=4:
  - sload_n low exactly 8 cycles.
  - Then exactly 8 sclk rising edges, each high 4 and low 4 cycles.
  - Then 1 COMMIT cycle and SCAN_WAIT idle cycles.
- Bounce: chain alternates 0x01/0x00 on successive scans, then holds 0x01.
  - switches stays at its old value until 4 consecutive 0x01 scans complete.
  - Then switches=0x01 with a single changed pulse.
- Bit order: chain model loaded with only switch bit 31 set (first out).
  - switches==32'h8000_0000, not 32'h0000_0001.
- Reset mid-SHIFT, asserted after 10 sclk edges:
  - Outputs return to reset values at once, with no spurious changed.
  - After release, the next full scan sequence commits normally after DEBOUNCE scans.
- DEBOUNCE=1: change the chain value every scan.
  - switches follows every scan, with changed pulsing each scan the value differs.
  - No pulse when two consecutive values are equal.
